// File: rtl/dsp_pkg.sv
// Shared constants for the DSP MAC pipeline: OPMODE field positions and
// the Z-select encodings for the post-adder.
package dsp_pkg;

  localparam int OP_PRE_EN  = 0;
  localparam int OP_PRE_SUB = 1;
  localparam int OP_ZSEL_LO = 2;
  localparam int OP_ZSEL_HI = 3;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'b00,
    ZSEL_C    = 2'b01,
    ZSEL_P    = 2'b10,
    ZSEL_PCIN = 2'b11
  } zsel_e;

endpackage

// File: rtl/dsp_sat_add.sv
// Post-adder: Z +/- (M + carry) evaluated one bit wider than the result,
// then either clamped (SAT=1) or wrapped (SAT=0), flagging overflow.
module dsp_sat_add #(
  parameter int PW  = 48,
  parameter int SAT = 1
) (
  input  logic [PW-1:0] z_i,
  input  logic [PW-1:0] m_i,
  input  logic          cin_i,
  input  logic          sub_i,
  output logic [PW-1:0] p_o,
  output logic          ovf_o
);

  localparam logic [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

  logic [PW:0] z_ext;
  logic [PW:0] addend;
  logic [PW:0] sum;

  always_comb begin
    z_ext  = {z_i[PW-1], z_i};
    // m_i holds a product far narrower than PW, so adding the carry here cannot overflow
    addend = {m_i[PW-1], m_i} + {{PW{1'b0}}, cin_i};
    sum    = sub_i ? (z_ext - addend) : (z_ext + addend);
    ovf_o  = sum[PW] ^ sum[PW-1];
    p_o    = sum[PW-1:0];
    if (ovf_o && (SAT != 0)) begin
      p_o = sum[PW] ? P_MIN : P_MAX;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage pre-add / multiply / post-add MAC with accumulate feedback,
// global clock enable and saturating or wrapping output.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int AW  = 18,
  parameter int BW  = 18,
  parameter int PW  = 48,
  parameter int SAT = 1
) (
  input  logic             clk,
  input  logic             RST_N,
  input  logic             CE,
  input  logic             IN_VALID,
  input  logic [AW-1:0]    A,
  input  logic [BW-1:0]    B,
  input  logic [BW-1:0]    D,
  input  logic [PW-1:0]    C,
  input  logic [PW-1:0]    PCIN,
  input  logic [3:0]       OPMODE,
  input  logic             SUB,
  input  logic             CARRYIN,
  output logic             OUT_VALID,
  output logic [PW-1:0]    P,
  output logic [PW-1:0]    PCOUT,
  output logic [AW+BW:0]   M,
  output logic             OVF
);

  localparam int MW = AW + BW + 1;

  // stage 1: operand capture
  logic [AW-1:0] a1_q;
  logic [BW-1:0] b1_q, d1_q;
  logic [PW-1:0] c1_q, pcin1_q;
  logic [3:0]    opmode1_q;
  logic          sub1_q, cin1_q, v1_q;

  // stage 2: product plus the controls the post-adder still needs
  logic [MW-1:0] m_q;
  logic [PW-1:0] c2_q, pcin2_q;
  logic [1:0]    zsel2_q;
  logic          sub2_q, cin2_q, v2_q;

  // stage 3: result
  logic [PW-1:0] p_q;
  logic          ovf_q, out_valid_q;

  logic signed [BW:0]   b_ext, d_ext, pre_sum;
  logic signed [MW-1:0] m_d;
  logic [PW-1:0]        z_sel, m_ext, p_d;
  logic                 ovf_d;
  zsel_e                zsel;

  always_comb begin
    b_ext = $signed({b1_q[BW-1], b1_q});
    d_ext = $signed({d1_q[BW-1], d1_q});
    if (!opmode1_q[OP_PRE_EN]) begin
      pre_sum = b_ext;
    end else if (opmode1_q[OP_PRE_SUB]) begin
      pre_sum = d_ext - b_ext;
    end else begin
      pre_sum = d_ext + b_ext;
    end
    m_d = $signed(a1_q) * pre_sum;
  end

  always_comb begin
    zsel  = zsel_e'(zsel2_q);
    m_ext = {{(PW-MW){m_q[MW-1]}}, m_q};
    z_sel = '0;
    unique case (zsel)
      ZSEL_ZERO: z_sel = '0;
      ZSEL_C:    z_sel = c2_q;
      // feeding back the live P register lets consecutive valids accumulate without a gap
      ZSEL_P:    z_sel = p_q;
      ZSEL_PCIN: z_sel = pcin2_q;
      default:   z_sel = '0;
    endcase
  end

  dsp_sat_add #(
    .PW  (PW),
    .SAT (SAT)
  ) u_sat_add (
    .z_i   (z_sel),
    .m_i   (m_ext),
    .cin_i (cin2_q),
    .sub_i (sub2_q),
    .p_o   (p_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      a1_q        <= '0;
      b1_q        <= '0;
      d1_q        <= '0;
      c1_q        <= '0;
      pcin1_q     <= '0;
      opmode1_q   <= '0;
      sub1_q      <= 1'b0;
      cin1_q      <= 1'b0;
      v1_q        <= 1'b0;
      m_q         <= '0;
      c2_q        <= '0;
      pcin2_q     <= '0;
      zsel2_q     <= '0;
      sub2_q      <= 1'b0;
      cin2_q      <= 1'b0;
      v2_q        <= 1'b0;
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (CE) begin
      a1_q        <= A;
      b1_q        <= B;
      d1_q        <= D;
      c1_q        <= C;
      pcin1_q     <= PCIN;
      opmode1_q   <= OPMODE;
      sub1_q      <= SUB;
      cin1_q      <= CARRYIN;
      v1_q        <= IN_VALID;
      m_q         <= m_d;
      c2_q        <= c1_q;
      pcin2_q     <= pcin1_q;
      zsel2_q     <= opmode1_q[OP_ZSEL_HI:OP_ZSEL_LO];
      sub2_q      <= sub1_q;
      cin2_q      <= cin1_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      // bubbles leave the accumulator and overflow flag untouched
      if (v2_q) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign OUT_VALID = out_valid_q;
  assign P         = p_q;
  assign PCOUT     = p_q;
  assign M         = m_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: one saturating and one wrapping instance
// share stimulus; every expected value below is hand-computed.
module tb_dsp_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic [17:0] a, b, d;
  logic [47:0] c, pcin;
  logic [3:0]  opmode;
  logic        sub, cin;

  logic               ov_s, ovf_s, ov_w, ovf_w;
  logic signed [47:0] p_s, pcout_s, p_w, pcout_w;
  logic signed [36:0] m_s, m_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.SAT(1)) u_sat (
    .clk(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid),
    .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .OPMODE(opmode),
    .SUB(sub), .CARRYIN(cin),
    .OUT_VALID(ov_s), .P(p_s), .PCOUT(pcout_s), .M(m_s), .OVF(ovf_s)
  );

  dsp_mac_pipe #(.SAT(0)) u_wrap (
    .clk(clk), .RST_N(rst_n), .CE(ce), .IN_VALID(in_valid),
    .A(a), .B(b), .D(d), .C(c), .PCIN(pcin), .OPMODE(opmode),
    .SUB(sub), .CARRYIN(cin),
    .OUT_VALID(ov_w), .P(p_w), .PCOUT(pcout_w), .M(m_w), .OVF(ovf_w)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // advance one clock edge, then settle so outputs are sampled off the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int av, input int bv, input int dv,
                         input logic [47:0] cv, input logic [3:0] op,
                         input logic sv, input logic ci);
    a = 18'(av); b = 18'(bv); d = 18'(dv);
    c = cv; opmode = op; sub = sv; cin = ci;
  endtask

  // one valid operand set followed by two idle cycles: result loads on the 3rd edge
  task automatic run_one();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; in_valid = 1'b0; pcin = '0;
    set_ops(0, 0, 0, 48'd0, 4'b0000, 1'b0, 1'b0);
    #3;
    chk("rst_p", p_s, 0);
    chk("rst_ov", ov_s, 0);
    chk("rst_m", m_s, 0);
    chk("rst_ovf", ovf_s, 0);
    tick();
    rst_n = 1'b1;

    // pre-add D+B, Z=C, carry in
    set_ops(10, 20, 15, 48'd10, 4'b0101, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat1_ov", ov_s, 0);
    tick();
    chk("add_m", m_s, 350);
    chk("lat2_ov", ov_s, 0);
    tick();
    chk("add_p", p_s, 361);
    chk("add_pcout", pcout_s, 361);
    chk("add_ov", ov_s, 1);
    chk("add_ovf", ovf_s, 0);
    tick();
    chk("add_pulse_end", ov_s, 0);
    chk("add_p_hold", p_s, 361);

    // pre-subtract D-B
    set_ops(10, 20, 15, 48'd10, 4'b0111, 1'b0, 1'b1);
    run_one();
    chk("psub_m", m_s, -50);
    chk("psub_p", p_s, -39);

    // Z=PCIN with post-subtract: 1000 - (3*4 + 1)
    pcin = 48'd1000;
    set_ops(3, 4, 0, 48'd0, 4'b1100, 1'b1, 1'b1);
    run_one();
    chk("pcin_sub_p", p_s, 987);
    pcin = '0;

    // accumulate Z=P, four back-to-back valids then a bubble
    do_reset();
    chk("acc_rst_p", p_s, 0);
    set_ops(2, 3, 0, 48'd0, 4'b1000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      in_valid = (k < 4);
      tick();
      if (k >= 2 && k <= 5) begin
        chk($sformatf("acc_p%0d", k), p_s, 6 * (k - 1));
        chk($sformatf("acc_ov%0d", k), ov_s, 1);
      end
    end
    chk("acc_bubble_p", p_s, 24);
    chk("acc_bubble_ov", ov_s, 0);

    // positive overflow: (2^47-1) + 1
    do_reset();
    set_ops(1, 1, 0, 48'h7FFF_FFFF_FFFF, 4'b0100, 1'b0, 1'b0);
    run_one();
    chk("ovp_sat_p", p_s, 64'sh7FFF_FFFF_FFFF);
    chk("ovp_sat_ovf", ovf_s, 1);
    chk("ovp_wrap_p", p_w, -64'sh8000_0000_0000);
    chk("ovp_wrap_ovf", ovf_w, 1);

    // negative overflow: -2^47 - 1
    set_ops(1, 1, 0, 48'h8000_0000_0000, 4'b0100, 1'b1, 1'b0);
    run_one();
    chk("ovn_sat_p", p_s, -64'sh8000_0000_0000);
    chk("ovn_sat_ovf", ovf_s, 1);
    chk("ovn_wrap_p", p_w, 64'sh7FFF_FFFF_FFFF);
    chk("ovn_wrap_ovf", ovf_w, 1);

    // in-range result clears OVF
    set_ops(1, 5, 0, 48'd0, 4'b0100, 1'b0, 1'b0);
    run_one();
    chk("ovf_clear_p", p_s, 5);
    chk("ovf_clear", ovf_s, 0);

    // CE stall mid-stream: P = B with A=1, Z=C=0
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      set_ops(1, k, 0, 48'd0, 4'b0100, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
    end
    chk("stall_pre_p", p_s, 1);
    chk("stall_pre_ov", ov_s, 1);
    set_ops(1, 4, 0, 48'd0, 4'b0100, 1'b0, 1'b0);
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk($sformatf("stall_p%0d", k), p_s, 1);
      chk($sformatf("stall_ov%0d", k), ov_s, 1);
      chk($sformatf("stall_m%0d", k), m_s, 2);
    end
    ce = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("resume_p2", p_s, 2);
    chk("resume_m3", m_s, 3);
    tick();
    chk("resume_p3", p_s, 3);
    tick();
    chk("resume_p4", p_s, 4);
    chk("resume_ov4", ov_s, 1);
    tick();
    chk("resume_end_ov", ov_s, 0);
    chk("resume_end_p", p_s, 4);

    // asynchronous reset with two results in flight
    set_ops(1, 5, 0, 48'd0, 4'b0100, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick();
    set_ops(1, 6, 0, 48'd0, 4'b0100, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_p", p_s, 0);
    chk("arst_ov", ov_s, 0);
    chk("arst_m", m_s, 0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("arst_stale_ov%0d", k), ov_s, 0);
      chk($sformatf("arst_stale_p%0d", k), p_s, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 Parameter AW, default 18: A operand width, signed.
REQ-002 Parameter BW, default 18: B/D operand width, signed.
REQ-003 Parameter PW, default 48: C/PCIN/P width, signed; SHALL be >= AW+BW+2.
REQ-004 Parameter SAT, default 1: 1 = saturate the post-adder result, 0 = wrap.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 CE  in  1  global clock enable; 0 = whole pipeline stalls.
REQ-008 IN_VALID  in  1  the operand set on this cycle is valid.
REQ-009 A  in  AW; B  in  BW; D  in  BW; C  in  PW; PCIN  in  PW: operands.
REQ-010 OPMODE  in  4  bit0 pre-adder enable; bit1 pre-subtract (D-B); bits3:2 Z select (00 zero, 01 C, 10 P, 11 PCIN).
REQ-011 SUB  in  1  post-adder computes Z-(M+CARRYIN) when 1, Z+M+CARRYIN when 0.
REQ-012 CARRYIN  in  1  post-adder carry input.
REQ-013 OUT_VALID  out  1  P holds a new result this cycle.
REQ-014 P  out  PW; PCOUT  out  PW (equal to P): result.
REQ-015 M  out  AW+BW+1  registered product.
REQ-016 OVF  out  1  the last loaded result overflowed PW (clamped or wrapped).

Function
REQ-017 Stage 1 SHALL register A, B, D, C, PCIN, OPMODE, SUB, CARRYIN and IN_VALID when CE=1.
REQ-018 Pre-adder (BW+1 bits): OPMODE[0]=0 -> B; [0]=1,[1]=0 -> D+B; [0]=1,[1]=1 -> D-B.
REQ-019 Stage 2 SHALL register the signed product A*preadd (AW+BW+1 bits) into M, together with the control fields and valid, when CE=1.
REQ-020 Stage 3 SHALL form Z ± (sign-extended M + CARRYIN) at PW+1 bits and load P only when CE=1 and stage-2 valid=1; otherwise P and OVF SHALL hold.
REQ-021 Z=P SHALL use the current P register value, so back-to-back valid accumulates chain with no gap; bubbles SHALL NOT disturb the accumulator.
REQ-022 Overflow (the PW+1 sum is not representable in PW): SAT=1 -> P clamps to 2^(PW-1)-1 or -2^(PW-1); SAT=0 -> P takes the low PW bits; OVF=1 in both cases, otherwise OVF=0.
REQ-023 Latency SHALL be 3 enabled cycles from IN_VALID to OUT_VALID; throughput SHALL be one result per enabled cycle.
REQ-024 OUT_VALID SHALL be a registered, one-cycle-per-result pulse; with CE=0 it SHALL hold its value.

Reset
REQ-025 RST_N=0 SHALL immediately clear every register (P, PCOUT, M, OVF, OUT_VALID and all stage data/valid) to 0, regardless of CE or clk.
REQ-026 Reset asserted mid-operation SHALL discard in-flight data; no OUT_VALID SHALL follow for operands accepted before reset.
REQ-027 The first valid result after reset SHALL appear 3 enabled cycles after the first IN_VALID.

Structure
REQ-028 Package dsp_pkg SHALL hold the OPMODE bit positions and the Z-select code constants (ZSEL_ZERO, ZSEL_C, ZSEL_P, ZSEL_PCIN).
REQ-029 Sub-module dsp_sat_add (combinational, parametrised PW, SAT) SHALL implement the post-adder, saturation and OVF; the pipeline stages live in dsp_mac_pipe.

Verification
REQ-030 Defaults; A=10, B=20, D=15, C=10, CARRYIN=1, OPMODE=0101, SUB=0, one valid -> P=361, OUT_VALID pulse 3 cycles later, M=350.
REQ-031 Same operands with OPMODE=0111 -> M=-50, P=-39.
REQ-032 After reset, A=2, B=3, OPMODE=1000, four consecutive valids -> P=6, 12, 18, 24 on successive cycles; then one IN_VALID=0 bubble -> P holds 24.
REQ-033 SAT=1: C=2^47-1, A=1, B=1, OPMODE=0100 -> P=2^47-1, OVF=1; rerun with SAT=0 -> P=-2^47, OVF=1.
REQ-034 CE=0 for 2 cycles mid-stream -> all outputs frozen; results resume in order with no loss or duplication.
REQ-035 RST_N pulsed low between clock edges with 2 results in flight -> P=0, OUT_VALID=0 immediately and no stale OUT_VALID afterward.
